// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: one digit per clock, LSD first, start/busy/done handshake.
// Optional operand digit check (err output) enabled by defining BCD_SUB_CHECK_EN.
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  borrow_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  borrow_out,
`ifdef BCD_SUB_CHECK_EN
  output logic                  err,
`endif
  output logic [0:0]            dbg_state_o
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS) + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Handshake: start is sampled only while busy==0; done pulses for one cycle
  // when diff/borrow_out carry the new result.
  logic [0:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  work_q, work_d;
  logic          brw_q, brw_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;
`ifdef BCD_SUB_CHECK_EN
  logic          bad_q, bad_d;
  logic          err_q, err_d;
  logic          bad_in;
`endif

  logic [4:0]    t5;
  logic          neg;
  logic [3:0]    dig;
  logic          last;
  logic [W-1:0]  work_next;

  // Low nibbles of the shift registers always hold the current digit pair.
  always_comb begin
    t5   = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0000, brw_q};
    neg  = t5[4];
    dig  = neg ? (t5[3:0] + 4'd10) : t5[3:0];
    last = (idx_q == IW'(DIGITS - 1));
  end

  // Result digits enter at the top and shift down, so after DIGITS steps digit 0 sits at [3:0].
  generate
    if (DIGITS == 1) begin : g_one
      assign work_next = dig;
    end else begin : g_many
      assign work_next = {dig, work_q[W-1:4]};
    end
  endgenerate

`ifdef BCD_SUB_CHECK_EN
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) bad_in = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    brw_d   = brw_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef BCD_SUB_CHECK_EN
    bad_d   = bad_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = borrow_in;
          work_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
`ifdef BCD_SUB_CHECK_EN
          bad_d   = bad_in;
`endif
        end
      end
      S_RUN: begin
        a_d    = a_q >> 4;
        b_d    = b_q >> 4;
        brw_d  = neg;
        work_d = work_next;
        if (last) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = work_next;
          bout_d  = neg;
`ifdef BCD_SUB_CHECK_EN
          err_d   = bad_q;
          if (bad_q) begin
            diff_d = '0;
            bout_d = 1'b0;
          end
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      brw_q   <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef BCD_SUB_CHECK_EN
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      brw_q   <= brw_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef BCD_SUB_CHECK_EN
      bad_q   <= bad_d;
      err_q   <= err_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign diff        = diff_q;
  assign borrow_out  = bout_q;
  assign dbg_state_o = state_q;
`ifdef BCD_SUB_CHECK_EN
  assign err         = err_q;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Table-driven bench for bcd_serial_subtractor (DIGITS=4) plus hand-written
// sequences for back-to-back, busy-ignore, reset-abort and digit-check cases.
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic [0:0]   dbg_state;
`ifdef BCD_SUB_CHECK_EN
  logic         err;
`endif

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
`ifdef BCD_SUB_CHECK_EN
    .err        (err),
`endif
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];
  logic [W:0] last_res;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] ed;
    logic         eb;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (edge k).
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin,
                        input logic [W-1:0] ed, input logic eb);
    exp_q.push_back({eb, ed});
    a         = av;
    b         = bv;
    borrow_in = bin;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    borrow_in = 1'($urandom_range(0, 1));
    check("busy_after_capture", {63'd0, busy}, 64'd1);
    check("done_low_after_capture", {63'd0, done}, 64'd0);
  endtask

  // Waits (bounded) for done; 'already' is the number of negedges past edge k consumed.
  task automatic wait_done(input string name, input int already, input logic exp_err);
    int lat;
    logic got;
    logic [W:0] e;
    lat = already;
    got = 1'b0;
    for (int c = 0; c < 3 * DIGITS + 4 && !got; c++) begin
      @(negedge clk);
      lat++;
      if (done) got = 1'b1;
    end
    if (!got) begin
      check({name, "_done_timeout"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      last_res = e;
      check({name, "_latency"}, 64'(lat), 64'(DIGITS));
      check({name, "_diff"}, 64'(diff), 64'(e[W-1:0]));
      check({name, "_borrow_out"}, {63'd0, borrow_out}, {63'd0, e[W]});
      check({name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
`ifdef BCD_SUB_CHECK_EN
      check({name, "_err"}, {63'd0, err}, {63'd0, exp_err});
`else
      if (exp_err) check({name, "_unexpected_err_vector"}, 64'd0, 64'd1);
`endif
    end
  endtask

  // One cycle after done: pulse gone, result held.
  task automatic settle(input string name);
    @(negedge clk);
    check({name, "_done_pulse_width"}, {63'd0, done}, 64'd0);
    check({name, "_diff_held"}, 64'(diff), 64'(last_res[W-1:0]));
  endtask

  initial begin
    vecs[0] = '{16'h0725, 16'h0318, 1'b0, 16'h0407, 1'b0};
    vecs[1] = '{16'h0100, 16'h0001, 1'b1, 16'h0098, 1'b0};
    vecs[2] = '{16'h0002, 16'h0005, 1'b0, 16'h9997, 1'b1};
    vecs[3] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1};
    vecs[4] = '{16'h5000, 16'h4999, 1'b0, 16'h0001, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1};
    vecs[6] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0};
    vecs[7] = '{16'h9999, 16'h0000, 1'b1, 16'h9998, 1'b0};
    vecs[8] = '{16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1};
    vecs[9] = '{16'h4321, 16'h1234, 1'b0, 16'h3087, 1'b0};

    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_diff", 64'(diff), 64'd0);
    check("reset_borrow_out", {63'd0, borrow_out}, 64'd0);
    check("reset_state", {63'd0, dbg_state}, 64'd0);
`ifdef BCD_SUB_CHECK_EN
    check("reset_err", {63'd0, err}, 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // table of vectors, each with an idle cycle after done
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].ed, vecs[i].eb);
      // result of the previous op must be untouched mid-run
      if (i > 0) begin
        @(negedge clk);
        check($sformatf("vec%0d_diff_held_in_run", i), 64'(diff), 64'(last_res[W-1:0]));
        wait_done($sformatf("vec%0d", i), 1, 1'b0);
      end else begin
        wait_done($sformatf("vec%0d", i), 0, 1'b0);
      end
      settle($sformatf("vec%0d", i));
    end

    // back-to-back: new start in the same cycle as done
    launch(16'h0002, 16'h0005, 1'b0, 16'h9997, 1'b1);
    wait_done("b2b_first", 0, 1'b0);
    launch(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1);
    wait_done("b2b_second", 0, 1'b0);
    settle("b2b_second");

    // start re-pulsed while busy is ignored
    launch(16'h0725, 16'h0318, 1'b0, 16'h0407, 1'b0);
    a = 16'h0002; b = 16'h0005; borrow_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_ignore", 1, 1'b0);
    settle("busy_ignore");

    // reset in the 2nd RUN cycle aborts the operation
    launch(16'h0725, 16'h0318, 1'b0, 16'h0407, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_diff", 64'(diff), 64'd0);
    check("abort_state", {63'd0, dbg_state}, 64'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 2 * DIGITS + 2; c++) begin
        @(negedge clk);
        if (done || busy) seen = 1'b1;
      end
      check("abort_no_done", {63'd0, seen}, 64'd0);
    end
    launch(16'h0725, 16'h0318, 1'b0, 16'h0407, 1'b0);
    wait_done("after_abort", 0, 1'b0);
    settle("after_abort");

    // invalid digit handling
`ifdef BCD_SUB_CHECK_EN
    launch(16'h00A3, 16'h0001, 1'b0, 16'h0000, 1'b0);
    wait_done("bad_digit", 0, 1'b1);
    @(negedge clk);
    check("bad_digit_err_held", {63'd0, err}, 64'd1);
    launch(16'h0725, 16'h0318, 1'b0, 16'h0407, 1'b0);
    wait_done("valid_after_bad", 0, 1'b0);
`else
    launch(16'h00A3, 16'h0001, 1'b0, 16'h00A2, 1'b0);
    wait_done("bad_digit_arith", 0, 1'b0);
`endif
    settle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
